dmem_responder: RTL

Data-memory responder serving the MEM-stage memory interface: it accepts the stage's word writes (`write_mem_en/addr/data`) and load requests, and returns load data one cycle later. Writes are posted into a small in-order write buffer and drained to a single-port word array in cycles with no load. Loads get store-to-load forwarding from the buffer so the pipeline never reads stale data. The block sits between the MEM stage and the WB stage's `read_mem_out` input.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM stage.
// Stores are posted into an in-order circular write buffer and drained into a
// single-port word array in cycles without an accepted load. Loads return
// registered data one cycle after acceptance.
// Optional feature macro: DMEM_FWD_EN
//   defined   -> store-to-load forwarding from the buffer, never stalls.
//   undefined -> a load that hits a buffered address stalls until it drains.
module dmem_responder #(
  parameter int WBUF_DEPTH = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int ADR_BIT    = 32,
  parameter int GPR_BIT    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_mem_en,
  input  logic [ADR_BIT-1:0] write_mem_addr,
  input  logic [GPR_BIT-1:0] write_mem_data,
  input  logic               read_mem_en,
  input  logic [ADR_BIT-1:0] read_mem_addr,
  output logic [GPR_BIT-1:0] read_mem_out,
  output logic               read_mem_valid,
  output logic               read_mem_stall,
  output logic               wbuf_full,
  output logic               wbuf_empty,
  output logic               wbuf_overflow
);

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Buffer control state
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [GPR_BIT-1:0] r_rd_data;
  logic               r_rd_valid;
  logic               r_overflow;

  // Buffer payload and the word array (never reset)
  logic [ADR_BIT-1:0] r_wb_addr [WBUF_DEPTH];
  logic [GPR_BIT-1:0] r_wb_data [WBUF_DEPTH];
  logic [GPR_BIT-1:0] r_mem     [MEM_WORDS];

  logic               w_full;
  logic               w_empty;
  logic               w_hit;
  logic [PTR_W-1:0]   w_scan_idx;
  logic               w_stall;
  logic               w_load;
  logic               w_drain;
  logic               w_push;
  logic [GPR_BIT-1:0] w_rd_next;
`ifdef DMEM_FWD_EN
  logic [GPR_BIT-1:0] w_fwd_data;
`endif

  assign w_full  = (r_count == CNT_W'(WBUF_DEPTH));
  assign w_empty = (r_count == '0);

  // Scan valid entries oldest to newest; the last hit wins, so the newest
  // matching store supplies the forwarded data.
  always_comb begin
    w_hit      = 1'b0;
    w_scan_idx = '0;
`ifdef DMEM_FWD_EN
    w_fwd_data = '0;
`endif
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_wb_addr[w_scan_idx] == read_mem_addr)) begin
        w_hit = 1'b1;
`ifdef DMEM_FWD_EN
        w_fwd_data = r_wb_data[w_scan_idx];
`endif
      end
    end
  end

`ifdef DMEM_FWD_EN
  assign w_stall   = 1'b0;
  assign w_rd_next = w_hit ? w_fwd_data : r_mem[read_mem_addr[IDX_W-1:0]];
`else
  // Without forwarding, a load to a buffered address must wait for the drain.
  assign w_stall   = read_mem_en & w_hit;
  assign w_rd_next = r_mem[read_mem_addr[IDX_W-1:0]];
`endif

  // Single array port: an accepted load wins, otherwise drain the head.
  assign w_load  = read_mem_en & ~w_stall;
  assign w_drain = ~w_load & ~w_empty;
  // Fullness is taken from the start-of-cycle count; a same-cycle drain
  // does not make room for this store.
  assign w_push  = write_mem_en & ~w_full;

  // Pointers, occupancy, load response and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)  r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rd_valid <= w_load;
      if (w_load) r_rd_data <= w_rd_next;
      if (write_mem_en && w_full) r_overflow <= 1'b1;
    end
  end

  // Buffer payload write and head drain into the array
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= write_mem_addr;
      r_wb_data[r_tail] <= write_mem_data;
    end
    if (w_drain) begin
      r_mem[r_wb_addr[r_head][IDX_W-1:0]] <= r_wb_data[r_head];
    end
  end

  assign read_mem_out   = r_rd_data;
  assign read_mem_valid = r_rd_valid;
  assign read_mem_stall = w_stall;
  assign wbuf_full      = w_full;
  assign wbuf_empty     = w_empty;
  assign wbuf_overflow  = r_overflow;

endmodule
